// File: rtl/dual_ram_arbiter_if.sv
// Bundle of the two requester channels and the shared RAM port seen by dual_ram_arbiter.
// The arbiter uses the slave modport; the client/RAM side uses master.
interface dual_ram_arbiter_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
);
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] din1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] dout1;

    logic              req2;
    logic              we2;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] din2;
    logic              gnt2;
    logic              rvalid2;
    logic [DATA_W-1:0] dout2;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic              ram_en;
    logic [DATA_W-1:0] ram_dout;
    logic              busy;

    modport slave (
        input  req1, we1, addr1, din1, req2, we2, addr2, din2, ram_dout,
        output gnt1, rvalid1, dout1, gnt2, rvalid2, dout2,
        output ram_addr, ram_din, ram_we, ram_en, busy
    );

    modport master (
        output req1, we1, addr1, din1, req2, we2, addr2, din2, ram_dout,
        input  gnt1, rvalid1, dout1, gnt2, rvalid2, dout2,
        input  ram_addr, ram_din, ram_we, ram_en, busy
    );
endinterface

// File: rtl/dual_ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port between two single-beat requesters.
// Read data returns in grant order to its owner, RD_LAT+2 cycles after the grant.
module dual_ram_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 1
) (
    input logic               clk,
    input logic               rst_n,
    dual_ram_arbiter_if.slave bus
);

    typedef enum logic {PtrReq1, PtrReq2} ptr_e;

    ptr_e              ptr_q, ptr_d;
    logic              gnt1, gnt2;
    logic              acc, acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_din;

    logic              ram_en_q, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_din_q;

    // Bit k of the tag pipeline is valid in cycle T+1+k for a read granted in cycle T
    logic [RD_LAT:0]   tag_v_q, tag_o_q;
    logic              ret1, ret2;
    logic              rvalid1_q, rvalid2_q;
    logic [DATA_W-1:0] dout1_q, dout2_q;

    always_comb begin
        gnt1     = bus.req1 & (~bus.req2 | (ptr_q == PtrReq1));
        gnt2     = bus.req2 & (~bus.req1 | (ptr_q == PtrReq2));
        acc      = gnt1 | gnt2;
        acc_we   = gnt2 ? bus.we2   : bus.we1;
        acc_addr = gnt2 ? bus.addr2 : bus.addr1;
        acc_din  = gnt2 ? bus.din2  : bus.din1;
        ptr_d    = ptr_q;
        if (gnt1) begin
            ptr_d = PtrReq2;
        end else if (gnt2) begin
            ptr_d = PtrReq1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PtrReq1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            ram_en_q <= acc;
            ram_we_q <= acc & acc_we;
            if (acc) begin
                ram_addr_q <= acc_addr;
                ram_din_q  <= acc_din;
            end
        end
    end

    // Owner bit: 0 = requester 1, 1 = requester 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q <= '0;
            tag_o_q <= '0;
        end else begin
            tag_v_q <= {tag_v_q[RD_LAT-1:0], acc & ~acc_we};
            tag_o_q <= {tag_o_q[RD_LAT-1:0], gnt2};
        end
    end

    assign ret1 = tag_v_q[RD_LAT] & ~tag_o_q[RD_LAT];
    assign ret2 = tag_v_q[RD_LAT] &  tag_o_q[RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid1_q <= 1'b0;
            rvalid2_q <= 1'b0;
            dout1_q   <= '0;
            dout2_q   <= '0;
        end else begin
            rvalid1_q <= ret1;
            rvalid2_q <= ret2;
            if (ret1) begin
                dout1_q <= bus.ram_dout;
            end
            if (ret2) begin
                dout2_q <= bus.ram_dout;
            end
        end
    end

    assign bus.gnt1     = gnt1;
    assign bus.gnt2     = gnt2;
    assign bus.ram_en   = ram_en_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rvalid2  = rvalid2_q;
    assign bus.dout1    = dout1_q;
    assign bus.dout2    = dout2_q;
    assign bus.busy     = ram_en_q | (|tag_v_q) | rvalid1_q | rvalid2_q;

endmodule

// File: tb/tb_dual_ram_arbiter.sv
`timescale 1ns/1ps
// Bench for dual_ram_arbiter: directed scenarios plus randomized traffic, scored against a
// cycle-level model of grants, RAM port contents and in-order read returns.
module tb_dual_ram_arbiter;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 10;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dual_ram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
    dual_ram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

    dual_ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    dual_ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    // Synchronous RAMs behind each arbiter; cleared while reset is held
    logic [DW-1:0] mem_a [1024];
    logic [DW-1:0] rd_a;
    logic [DW-1:0] mem_b [1024];
    logic [DW-1:0] pipe_b [LAT_B];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else begin
            if (if_a.ram_en && if_a.ram_we) mem_a[if_a.ram_addr] <= if_a.ram_din;
            if (if_b.ram_en && if_b.ram_we) mem_b[if_b.ram_addr] <= if_b.ram_din;
        end
        rd_a      <= mem_a[if_a.ram_addr];
        pipe_b[0] <= mem_b[if_b.ram_addr];
        for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign if_a.ram_dout = rd_a;
    assign if_b.ram_dout = pipe_b[LAT_B-1];

    typedef struct {
        int          due;
        int          owner;
        bit [DW-1:0] data;
    } rd_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model state
    rd_t         rq[$];
    int          m_ptr = 1;
    bit [DW-1:0] ref_mem [1024];
    bit          e_en = 0, e_we = 0;
    bit [AW-1:0] e_addr = '0;
    bit [DW-1:0] e_din = '0, e_d1 = '0, e_d2 = '0;
    bit          m_g1, m_g2, m_r1, m_r2, m_bsy, m_we;
    bit [AW-1:0] m_ad;
    bit [DW-1:0] m_dn;

    always @(negedge clk) begin
        if (!rst_n) begin
            tests++;
            if ({if_a.ram_en, if_a.ram_we, if_a.rvalid1, if_a.rvalid2, if_a.busy} !== 5'b0 ||
                if_a.ram_addr !== '0 || if_a.ram_din !== '0 ||
                if_a.dout1 !== '0 || if_a.dout2 !== '0) begin
                fails++;
                $display("FAIL reset_values cyc=%0d got en=%b we=%b rv=%b%b busy=%b addr=%0d din=%0d d1=%0d d2=%0d required all 0",
                         cyc, if_a.ram_en, if_a.ram_we, if_a.rvalid1, if_a.rvalid2, if_a.busy,
                         if_a.ram_addr, if_a.ram_din, if_a.dout1, if_a.dout2);
            end
            m_ptr = 1;
            rq.delete();
            e_en = 0; e_we = 0; e_addr = '0; e_din = '0; e_d1 = '0; e_d2 = '0;
            for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        end else begin
            m_g1 = if_a.req1 && (!if_a.req2 || m_ptr == 1);
            m_g2 = if_a.req2 && (!if_a.req1 || m_ptr == 2);
            tests++;
            if ({if_a.gnt1, if_a.gnt2} !== {m_g1, m_g2}) begin
                fails++;
                $display("FAIL grant cyc=%0d got=%b%b required=%b%b",
                         cyc, if_a.gnt1, if_a.gnt2, m_g1, m_g2);
            end
            tests++;
            if ({if_a.ram_en, if_a.ram_we, if_a.ram_addr, if_a.ram_din} !==
                {e_en, e_en & e_we, e_addr, e_din}) begin
                fails++;
                $display("FAIL ram_port cyc=%0d got en=%b we=%b a=%0d d=%0d required en=%b we=%b a=%0d d=%0d",
                         cyc, if_a.ram_en, if_a.ram_we, if_a.ram_addr, if_a.ram_din,
                         e_en, e_en & e_we, e_addr, e_din);
            end
            m_bsy = e_en || (rq.size() != 0);
            m_r1 = 0;
            m_r2 = 0;
            if (rq.size() != 0 && rq[0].due == cyc) begin
                if (rq[0].owner == 1) begin m_r1 = 1; e_d1 = rq[0].data; end
                else begin m_r2 = 1; e_d2 = rq[0].data; end
                void'(rq.pop_front());
            end
            tests++;
            if ({if_a.rvalid1, if_a.rvalid2} !== {m_r1, m_r2}) begin
                fails++;
                $display("FAIL rvalid cyc=%0d got=%b%b required=%b%b",
                         cyc, if_a.rvalid1, if_a.rvalid2, m_r1, m_r2);
            end
            tests++;
            if ({if_a.dout1, if_a.dout2} !== {e_d1, e_d2}) begin
                fails++;
                $display("FAIL dout cyc=%0d got d1=%0d d2=%0d required d1=%0d d2=%0d",
                         cyc, if_a.dout1, if_a.dout2, e_d1, e_d2);
            end
            tests++;
            if (if_a.busy !== m_bsy) begin
                fails++;
                $display("FAIL busy cyc=%0d got=%b required=%b", cyc, if_a.busy, m_bsy);
            end
            e_en = m_g1 || m_g2;
            e_we = 0;
            if (m_g1 || m_g2) begin
                m_we = m_g1 ? if_a.we1 : if_a.we2;
                m_ad = m_g1 ? if_a.addr1 : if_a.addr2;
                m_dn = m_g1 ? if_a.din1 : if_a.din2;
                e_we = m_we; e_addr = m_ad; e_din = m_dn;
                if (m_we) ref_mem[m_ad] = m_dn;
                else rq.push_back('{due: cyc + int'(LAT_A) + 2, owner: m_g1 ? 1 : 2,
                                    data: ref_mem[m_ad]});
                m_ptr = m_g1 ? 2 : 1;
            end
        end
        cyc++;
    end

    task automatic set_req(input int who, input bit rq_on, input bit we, input int addr,
                           input int din);
        if (who == 1) begin
            if_a.req1 = rq_on; if_a.we1 = we; if_a.addr1 = AW'(addr); if_a.din1 = DW'(din);
        end else begin
            if_a.req2 = rq_on; if_a.we2 = we; if_a.addr2 = AW'(addr); if_a.din2 = DW'(din);
        end
    endtask

    // Drives one command and holds it until granted; returns grant cycle and wait count
    task automatic send(input int who, input bit we, input int addr, input int din,
                        output int gcyc, output int waits);
        bit done = 0;
        gcyc = -1;
        waits = -1;
        @(posedge clk); #1;
        set_req(who, 1'b1, we, addr, din);
        #3;
        for (int k = 0; k < 8 && !done; k++) begin
            if (k > 0) begin @(posedge clk); #4; end
            if ((who == 1 && if_a.gnt1 === 1'b1) || (who == 2 && if_a.gnt2 === 1'b1)) begin
                done = 1; gcyc = cyc; waits = k;
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL send_timeout who=%0d got no gnt required gnt", who);
        end
    endtask

    task automatic release_req();
        @(posedge clk); #1;
        if_a.req1 = 1'b0;
        if_a.req2 = 1'b0;
        #3;
    endtask

    task automatic wait_rvalid(input int who, input int g, output int lat,
                               output logic [DW-1:0] d, output bit other);
        lat = -1; d = '0; other = 0;
        for (int k = 0; k < 16 && lat < 0; k++) begin
            @(posedge clk); #4;
            if ((who == 1 ? if_a.rvalid2 : if_a.rvalid1) === 1'b1) other = 1;
            if ((who == 1 ? if_a.rvalid1 : if_a.rvalid2) === 1'b1) begin
                lat = cyc - g;
                d = (who == 1) ? if_a.dout1 : if_a.dout2;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        if_a.req1 = 0; if_a.req2 = 0; if_b.req1 = 0; if_b.req2 = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #4;
        tests++;
        if ({if_a.ram_en, if_a.busy, if_a.rvalid1, if_b.ram_en, if_b.busy, if_b.rvalid1} !== 6'b0
            || if_b.dout1 !== '0 || if_b.ram_addr !== '0) begin
            fails++;
            $display("FAIL reset_both got a_en=%b a_busy=%b b_en=%b b_busy=%b required 0",
                     if_a.ram_en, if_a.busy, if_b.ram_en, if_b.busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single_writer();
        int g, w, lat;
        logic [DW-1:0] d;
        bit other;
        send(1, 1'b1, 1001, 210, g, w);
        tests++;
        if (w != 0) begin fails++; $display("FAIL sw_write_wait got=%0d required=0", w); end
        release_req();
        tests++;
        if ({if_a.ram_en, if_a.ram_we, if_a.ram_addr, if_a.ram_din} !==
            {1'b1, 1'b1, AW'(1001), DW'(210)}) begin
            fails++;
            $display("FAIL sw_ram_port got en=%b we=%b a=%0d d=%0d required 1 1 1001 210",
                     if_a.ram_en, if_a.ram_we, if_a.ram_addr, if_a.ram_din);
        end
        send(1, 1'b0, 1001, 0, g, w);
        release_req();
        wait_rvalid(1, g, lat, d, other);
        tests++;
        if (lat != int'(LAT_A) + 2 || d !== DW'(210) || other) begin
            fails++;
            $display("FAIL sw_read got lat=%0d d=%0d rv2=%b required lat=%0d d=210 rv2=0",
                     lat, d, other, LAT_A + 2);
        end
    endtask

    task automatic test_contention();
        int n1 = 0, n2 = 0, first = 0, bad = 0;
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b1, 999, 110);
        set_req(2, 1'b1, 1'b1, 888, 110);
        #3;
        tests++;
        if ({if_a.gnt1, if_a.gnt2} !== 2'b10) begin
            fails++; $display("FAIL cont_w0 got=%b%b required=10", if_a.gnt1, if_a.gnt2);
        end
        @(posedge clk); #1 if_a.req1 = 1'b0; #3;
        tests++;
        if ({if_a.gnt1, if_a.gnt2} !== 2'b01) begin
            fails++; $display("FAIL cont_w1 got=%b%b required=01", if_a.gnt1, if_a.gnt2);
        end
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 999, 0);
        set_req(2, 1'b1, 1'b0, 888, 0);
        #3;
        tests++;
        if ({if_a.gnt1, if_a.gnt2} !== 2'b10) begin
            fails++; $display("FAIL cont_r0 got=%b%b required=10", if_a.gnt1, if_a.gnt2);
        end
        @(posedge clk); #1 if_a.req1 = 1'b0; #3;
        release_req();
        for (int k = 0; k < 8; k++) begin
            if (if_a.rvalid1 === 1'b1) begin
                n1++; if (first == 0) first = 1;
                if (if_a.dout1 !== DW'(110)) bad++;
            end
            if (if_a.rvalid2 === 1'b1) begin
                n2++; if (first == 0) first = 2;
                if (if_a.dout2 !== DW'(110)) bad++;
            end
            @(posedge clk); #4;
        end
        tests++;
        if (n1 != 1 || n2 != 1 || first != 1 || bad != 0) begin
            fails++;
            $display("FAIL cont_returns got n1=%0d n2=%0d first=%0d bad=%0d required 1 1 1 0",
                     n1, n2, first, bad);
        end
    endtask

    task automatic test_back_to_back();
        int addrs[8] = '{666, 698, 244, 444, 456, 446, 1010, 888};
        logic [DW-1:0] dat[8];
        int g, w, ng = 0, nr = 0, first = -1, gap = 0, bad = 0;
        for (int i = 0; i < 8; i++) begin
            dat[i] = DW'($urandom_range(0, 255));
            send(1, 1'b1, addrs[i], int'(dat[i]), g, w);
        end
        release_req();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k < 8) set_req(2, 1'b1, 1'b0, addrs[k], 0);
            else if_a.req2 = 1'b0;
            #3;
            if (k < 8 && if_a.gnt2 === 1'b1) ng++;
            if (if_a.rvalid2 === 1'b1) begin
                if (nr == 0) first = cyc;
                else if (cyc != first + nr) gap = 1;
                if (nr < 8 && if_a.dout2 !== dat[nr]) bad++;
                nr++;
            end
        end
        tests++;
        if (ng != 8 || nr != 8 || gap != 0 || bad != 0) begin
            fails++;
            $display("FAIL b2b got gnts=%0d rvalids=%0d gap=%0d bad=%0d required 8 8 0 0",
                     ng, nr, gap, bad);
        end
    endtask

    task automatic test_same_addr();
        int g, w, lat;
        logic [DW-1:0] d;
        bit other;
        send(1, 1'b1, 5, 7, g, w);
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b1, 777, 109);
        set_req(2, 1'b1, 1'b1, 777, 100);
        #3;
        tests++;
        if ({if_a.gnt1, if_a.gnt2} !== 2'b01) begin
            fails++; $display("FAIL race_first got=%b%b required=01", if_a.gnt1, if_a.gnt2);
        end
        @(posedge clk); #1 if_a.req2 = 1'b0; #3;
        tests++;
        if ({if_a.gnt1, if_a.gnt2} !== 2'b10) begin
            fails++; $display("FAIL race_second got=%b%b required=10", if_a.gnt1, if_a.gnt2);
        end
        send(2, 1'b0, 777, 0, g, w);
        release_req();
        wait_rvalid(2, g, lat, d, other);
        tests++;
        if (d !== DW'(109) || lat != int'(LAT_A) + 2) begin
            fails++; $display("FAIL race_read got d=%0d lat=%0d required d=109 lat=%0d",
                              d, lat, LAT_A + 2);
        end
    endtask

    task automatic test_reset_mid_read();
        int g, w, nrv = 0;
        send(1, 1'b0, 3, 0, g, w);
        send(1, 1'b0, 4, 0, g, w);
        @(posedge clk); #1;
        if_a.req1 = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #3;
            tests++;
            if ({if_a.ram_en, if_a.rvalid1, if_a.rvalid2, if_a.busy} !== 4'b0 ||
                if_a.ram_addr !== '0 || if_a.dout1 !== '0) begin
                fails++;
                $display("FAIL midrst_outputs k=%0d got en=%b rv1=%b busy=%b required 0",
                         k, if_a.ram_en, if_a.rvalid1, if_a.busy);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #3;
            if (if_a.rvalid1 !== 1'b0) nrv++;
            @(posedge clk); #1;
        end
        tests++;
        if (nrv != 0) begin fails++; $display("FAIL midrst_rvalid got=%0d required=0", nrv); end
        set_req(1, 1'b1, 1'b1, 9, 1);
        set_req(2, 1'b1, 1'b1, 10, 2);
        #3;
        tests++;
        if ({if_a.gnt1, if_a.gnt2} !== 2'b10) begin
            fails++; $display("FAIL midrst_ptr got=%b%b required=10", if_a.gnt1, if_a.gnt2);
        end
        @(posedge clk); #1 if_a.req1 = 1'b0; #3;
        release_req();
    endtask

    task automatic test_random();
        bit p1 = 0, p2 = 0;
        int w1 = 0, w2 = 0, idle_k = -1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; w1 = 0;
                set_req(1, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                        $urandom_range(0, 255));
            end
            if (!p2 && $urandom_range(0, 2) != 0) begin
                p2 = 1; w2 = 0;
                set_req(2, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                        $urandom_range(0, 255));
            end
            if_a.req1 = p1;
            if_a.req2 = p2;
            #3;
            if (p1) begin if (if_a.gnt1 === 1'b1) p1 = 0; else w1++; end
            if (p2) begin if (if_a.gnt2 === 1'b1) p2 = 0; else w2++; end
            if (w1 > 1 || w2 > 1) begin
                tests++; fails++;
                $display("FAIL rand_wait k=%0d got w1=%0d w2=%0d required <=1", k, w1, w2);
                w1 = 0; w2 = 0;
            end
        end
        release_req();
        for (int k = 0; k < 20 && idle_k < 0; k++) begin
            if (if_a.busy === 1'b0) idle_k = k;
            else begin @(posedge clk); #4; end
        end
        tests++;
        if (idle_k < 0) begin fails++; $display("FAIL rand_drain got busy=1 required busy=0"); end
    endtask

    task automatic test_rd_lat3();
        int g = 0, lat = -1;
        bit other = 0;
        logic [DW-1:0] d = '0;
        @(posedge clk); #1;
        if_b.req1 = 1'b1; if_b.we1 = 1'b1; if_b.addr1 = AW'(1001); if_b.din1 = DW'(210);
        #3;
        tests++;
        if (if_b.gnt1 !== 1'b1) begin fails++; $display("FAIL l3_wgnt got=%b required=1", if_b.gnt1); end
        @(posedge clk); #1 if_b.req1 = 1'b0; #3;
        tests++;
        if ({if_b.ram_en, if_b.ram_we, if_b.ram_addr} !== {1'b1, 1'b1, AW'(1001)}) begin
            fails++;
            $display("FAIL l3_ram_port got en=%b we=%b a=%0d required 1 1 1001",
                     if_b.ram_en, if_b.ram_we, if_b.ram_addr);
        end
        @(posedge clk); #1;
        if_b.req1 = 1'b1; if_b.we1 = 1'b0;
        #3;
        g = cyc;
        tests++;
        if (if_b.gnt1 !== 1'b1) begin fails++; $display("FAIL l3_rgnt got=%b required=1", if_b.gnt1); end
        @(posedge clk); #1 if_b.req1 = 1'b0; #3;
        for (int k = 0; k < 16 && lat < 0; k++) begin
            @(posedge clk); #4;
            if (if_b.rvalid2 === 1'b1) other = 1;
            if (if_b.rvalid1 === 1'b1) begin lat = cyc - g; d = if_b.dout1; end
        end
        tests++;
        if (lat != int'(LAT_B) + 2 || d !== DW'(210) || other) begin
            fails++;
            $display("FAIL l3_read got lat=%0d d=%0d rv2=%b required lat=%0d d=210 rv2=0",
                     lat, d, other, LAT_B + 2);
        end
    endtask

    initial begin
        if_a.req1 = 0; if_a.we1 = 0; if_a.addr1 = '0; if_a.din1 = '0;
        if_a.req2 = 0; if_a.we2 = 0; if_a.addr2 = '0; if_a.din2 = '0;
        if_b.req1 = 0; if_b.we1 = 0; if_b.addr1 = '0; if_b.din1 = '0;
        if_b.req2 = 0; if_b.we2 = 0; if_b.addr2 = '0; if_b.din2 = '0;
        test_reset();
        test_single_writer();
        do_reset();
        test_contention();
        test_back_to_back();
        test_same_addr();
        test_reset_mid_read();
        test_random();
        test_rd_lat3();
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
